// File: rtl/display_scan_mux_pkg.sv
// Shared types and digit codes for the scan mux and the downstream 7-segment decoder.
package display_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MINUS = 4'd10;
  localparam digit_t DIGIT_BLANK = 4'd11;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Bus between the numeric formatter (master) and the scan mux (slave).
// load is a fire-and-forget strobe with no ready: the mux accepts it on every clk edge with rst_n high.
interface display_scan_mux_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                        load;
  logic [(NUM_DIGITS-1)*4-1:0] digits_in;
  logic                        neg;
  logic                        blank_lz;
  logic [NUM_DIGITS-1:0]       digit_sel;
  digit_t                      num;
  logic                        decimal;
  logic                        frame_done;

  modport master (
    output load, digits_in, neg, blank_lz,
    input  digit_sel, num, decimal, frame_done
  );

  modport slave (
    input  load, digits_in, neg, blank_lz,
    output digit_sel, num, decimal, frame_done
  );

endinterface

// File: rtl/display_scan_timer.sv
// Digit dwell prescaler and scan index; wrap marks the last tick of a frame.
module display_scan_timer
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [width_of(NUM_DIGITS)-1:0] idx,
  output logic                            tick,
  output logic                            wrap
);

  localparam int CW = width_of(SCAN_DIV);
  localparam int IW = width_of(NUM_DIGITS);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= wrap ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// N-digit 7-segment scan controller with frame-aligned double buffering,
// sign digit, fixed decimal point and optional leading-zero blanking.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DP_POS     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  display_scan_mux_if.slave        bus
);

  localparam int IW    = width_of(NUM_DIGITS);
  localparam int MW    = (NUM_DIGITS - 1) * 4;
  localparam bit DP_EN = (DP_POS < NUM_DIGITS - 1);

  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  logic [MW-1:0] p_digits, a_digits;
  logic          p_neg, p_lz, p_valid;
  logic          a_neg, a_lz;
  logic          frame_done_q;

  display_scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx),
    .tick  (tick),
    .wrap  (wrap)
  );

  wrap_implies_tick: assert property (@(posedge clk) disable iff (!rst_n) wrap |-> tick);

  // A load coinciding with wrap bypasses the pending buffer so it is not delayed a whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_digits     <= '0;
      p_neg        <= 1'b0;
      p_lz         <= 1'b0;
      p_valid      <= 1'b0;
      a_digits     <= '0;
      a_neg        <= 1'b0;
      a_lz         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (wrap) begin
        if (bus.load) begin
          a_digits <= bus.digits_in;
          a_neg    <= bus.neg;
          a_lz     <= bus.blank_lz;
        end else if (p_valid) begin
          a_digits <= p_digits;
          a_neg    <= p_neg;
          a_lz     <= p_lz;
        end
        p_valid <= 1'b0;
      end else if (bus.load) begin
        p_digits <= bus.digits_in;
        p_neg    <= bus.neg;
        p_lz     <= bus.blank_lz;
        p_valid  <= 1'b1;
      end
    end
  end

  digit_t mag;
  logic   upper_zero;

  always_comb begin
    mag        = '0;
    upper_zero = 1'b1;
    // upper_zero: every magnitude digit from idx up to the top one is zero.
    for (int j = 0; j < NUM_DIGITS - 1; j++) begin
      if (idx == IW'(j)) mag = a_digits[4*j +: 4];
      if ((IW'(j) >= idx) && (a_digits[4*j +: 4] != 4'd0)) upper_zero = 1'b0;
    end
  end

  always_comb begin
    bus.digit_sel = NUM_DIGITS'(1) << idx;
    if (idx == IW'(NUM_DIGITS - 1)) begin
      bus.num = a_neg ? DIGIT_MINUS : DIGIT_BLANK;
    end else if (a_lz && (int'(idx) > DP_POS) && upper_zero) begin
      bus.num = DIGIT_BLANK;
    end else begin
      bus.num = mag;
    end
    bus.decimal    = DP_EN && (int'(idx) == DP_POS);
    bus.frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, SCAN_DIV=4, DP_POS=1.
module tb_display_scan_mux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  display_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  display_scan_mux #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .DP_POS     (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc counts edges since reset release; cyc % 16 = idx*4 + cnt.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto_pos(input int pos);
    while ((cyc % 16) != pos) step(1);
  endtask

  task automatic do_load(input logic [11:0] d, input logic n, input logic lz);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.neg       = n;
    bus.blank_lz  = lz;
    step(1);
    bus.load      = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] exp_sel;
    logic       exp_fd;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.digit_sel !== 4'b0001 || bus.num !== 4'd0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got sel=%b num=%0d fd=%b, want sel=0001 num=0 fd=0",
               bus.digit_sel, bus.num, bus.frame_done);
    end
    rst_n = 1'b1;
    cyc = 0;
    n_checks++;
    if (bus.digit_sel !== 4'b0001 || bus.num !== 4'd0 || bus.decimal !== 1'b0 ||
        bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got sel=%b num=%0d dp=%b fd=%b, want sel=0001 num=0 dp=0 fd=0",
               bus.digit_sel, bus.num, bus.decimal, bus.frame_done);
    end
    for (int k = 0; k < 40; k++) begin
      step(1);
      exp_sel = 4'b0001 << ((cyc / 4) % 4);
      exp_fd  = ((cyc % 16) == 0);
      n_checks++;
      if (bus.digit_sel !== exp_sel || bus.frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL scan_timing cyc=%0d: got sel=%b fd=%b, want sel=%b fd=%b",
                 cyc, bus.digit_sel, bus.frame_done, exp_sel, exp_fd);
      end
    end
  endtask

  task automatic test_basic;
    int exp_num[4] = '{7, 5, 2, 10};
    logic [3:0] exp_sel;
    do_load(12'h257, 1'b1, 1'b0);
    goto_pos(0);
    for (int i = 0; i < 4; i++) begin
      goto_pos(4 * i + 1);
      exp_sel = 4'b0001 << i;
      n_checks++;
      if (bus.num !== 4'(exp_num[i]) || bus.decimal !== (i == 1) || bus.digit_sel !== exp_sel) begin
        n_fail++;
        $display("FAIL basic idx%0d: got num=%0d dp=%b sel=%b, want num=%0d dp=%b sel=%b",
                 i, bus.num, bus.decimal, bus.digit_sel, exp_num[i], (i == 1), exp_sel);
      end
    end
  endtask

  task automatic test_double_buffer;
    int pos_t[6] = '{9, 13, 1, 5, 9, 13};
    int exp_t[6] = '{2, 10, 9, 9, 9, 11};
    goto_pos(8);
    do_load(12'h999, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      goto_pos(pos_t[k]);
      n_checks++;
      if (bus.num !== 4'(exp_t[k])) begin
        n_fail++;
        $display("FAIL double_buffer step%0d: got num=%0d, want num=%0d", k, bus.num, exp_t[k]);
      end
    end
  endtask

  task automatic test_blanking;
    int exp_lz[4] = '{3, 0, 11, 11};
    int exp_nb[4] = '{3, 0, 0, 11};
    for (int pass = 0; pass < 2; pass++) begin
      do_load(12'h003, 1'b0, (pass == 0));
      goto_pos(0);
      for (int i = 0; i < 4; i++) begin
        goto_pos(4 * i + 1);
        n_checks++;
        if (bus.num !== 4'(pass == 0 ? exp_lz[i] : exp_nb[i]) || bus.decimal !== (i == 1)) begin
          n_fail++;
          $display("FAIL blanking lz=%0d idx%0d: got num=%0d dp=%b, want num=%0d dp=%b",
                   (pass == 0), i, bus.num, bus.decimal,
                   (pass == 0 ? exp_lz[i] : exp_nb[i]), (i == 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int exp_a[4] = '{3, 2, 1, 11};
    int exp_b[4] = '{6, 6, 6, 11};
    goto_pos(15);
    do_load(12'h123, 1'b0, 1'b0);
    n_checks++;
    if (bus.frame_done !== 1'b1 || bus.num !== 4'd3) begin
      n_fail++;
      $display("FAIL load_at_wrap: got fd=%b num=%0d, want fd=1 num=3", bus.frame_done, bus.num);
    end
    for (int i = 0; i < 4; i++) begin
      goto_pos(4 * i + 1);
      n_checks++;
      if (bus.num !== 4'(exp_a[i])) begin
        n_fail++;
        $display("FAIL load_at_wrap idx%0d: got num=%0d, want num=%0d", i, bus.num, exp_a[i]);
      end
    end
    goto_pos(2);
    do_load(12'h444, 1'b0, 1'b0);
    goto_pos(6);
    do_load(12'h666, 1'b0, 1'b0);
    goto_pos(9);
    n_checks++;
    if (bus.num !== 4'd1) begin
      n_fail++;
      $display("FAIL two_loads_hold: got num=%0d, want num=1", bus.num);
    end
    goto_pos(0);
    for (int i = 0; i < 4; i++) begin
      goto_pos(4 * i + 1);
      n_checks++;
      if (bus.num !== 4'(exp_b[i])) begin
        n_fail++;
        $display("FAIL two_loads idx%0d: got num=%0d, want num=%0d", i, bus.num, exp_b[i]);
      end
    end
  endtask

  task automatic test_mid_frame_reset;
    int exp_r[4] = '{0, 0, 0, 11};
    goto_pos(8);
    do_load(12'h888, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    cyc = 0;
    n_checks++;
    if (bus.digit_sel !== 4'b0001 || bus.num !== 4'd0 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got sel=%b num=%0d fd=%b, want sel=0001 num=0 fd=0",
               bus.digit_sel, bus.num, bus.frame_done);
    end
    for (int k = 0; k < 8; k++) begin
      goto_pos(4 * (k % 4) + 1);
      n_checks++;
      if (bus.num !== 4'(exp_r[k % 4]) || bus.decimal !== ((k % 4) == 1)) begin
        n_fail++;
        $display("FAIL mid_reset frame%0d idx%0d: got num=%0d dp=%b, want num=%0d dp=%b",
                 k / 4, k % 4, bus.num, bus.decimal, exp_r[k % 4], ((k % 4) == 1));
      end
    end
  endtask

  task automatic test_load_in_reset;
    int exp_r[4] = '{0, 0, 0, 11};
    rst_n         = 1'b0;
    bus.load      = 1'b1;
    bus.digits_in = 12'h555;
    bus.neg       = 1'b1;
    bus.blank_lz  = 1'b0;
    step(1);
    bus.load = 1'b0;
    rst_n    = 1'b1;
    cyc      = 0;
    step(16);
    for (int i = 0; i < 4; i++) begin
      goto_pos(4 * i + 1);
      n_checks++;
      if (bus.num !== 4'(exp_r[i])) begin
        n_fail++;
        $display("FAIL load_in_reset idx%0d: got num=%0d, want num=%0d", i, bus.num, exp_r[i]);
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.neg       = 1'b0;
    bus.blank_lz  = 1'b0;
    test_reset();
    test_basic();
    test_double_buffer();
    test_blanking();
    test_back_to_back();
    test_mid_frame_reset();
    test_load_in_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised 7-segment scan controller for N digits. It generates its own digit scan timing, so no external 2-bit scan count is needed.
- Double-buffers the displayed value: a new value captured mid-frame takes effect only at the next frame boundary, so the display never shows a half-old, half-new value.
- Top digit is the sign position (minus or blank). It adds a parametrised decimal-point position and optional leading-zero blanking.
- Sits between the numeric formatting logic and the 7-segment decoder/anode drivers.

Parameters:
- NUM_DIGITS, 4, total digits including the sign digit; must be >= 2.
- SCAN_DIV, 50000, clk cycles per digit dwell; must be >= 1 (1 = advance every cycle).
- DP_POS, 1, digit index that lights the decimal point; values >= NUM_DIGITS-1 disable the decimal point.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  single-cycle strobe: capture digits_in/neg/blank_lz into the pending buffer.
- digits_in  in  (NUM_DIGITS-1)*4  magnitude digits; field i (bits 4i+3:4i) is digit i, with field 0 the least significant.
- neg  in  1  value is negative.
- blank_lz  in  1  enable leading-zero blanking.
- digit_sel  out  NUM_DIGITS  one-hot active-high select of the current digit.
- num  out  4  digit code for the decoder: 0-15 pass through; 10 = minus, 11 = blank.
- decimal  out  1  decimal point for the current digit.
- frame_done  out  1  one-cycle pulse marking the start of a new frame.

Behaviour:
- Prescaler cnt counts 0..SCAN_DIV-1. tick = (cnt == SCAN_DIV-1); cnt wraps to 0 on tick.
- Scan index idx increments on tick. wrap = tick && idx == NUM_DIGITS-1; on wrap, idx returns to 0.
- Pending buffer {p_digits, p_neg, p_lz, p_valid}:
  - load writes the fields and sets p_valid=1.
  - A second load before the next wrap overwrites the pending buffer; the last load wins.
- Active buffer {a_digits, a_neg, a_lz}:
  - On wrap with p_valid=1, the active buffer takes the pending contents and p_valid clears.
  - load in the same cycle as wrap: the active buffer takes the load-cycle inputs directly and p_valid stays 0.
- frame_done is a registered output, high for exactly one cycle, in the cycle after wrap (the first cycle with idx=0).
- Outputs digit_sel, num and decimal are combinational functions of idx and the active buffer only, never of the raw inputs.
  - digit_sel = 1 << idx.
  - idx == NUM_DIGITS-1 (sign digit): num = a_neg ? 10 : 11.
  - idx < NUM_DIGITS-1 (magnitude digit): num = a_digits[idx]; it is forced to 11 when a_lz=1, idx > DP_POS, and every a_digits[j] for idx <= j <= NUM_DIGITS-2 equals 0.
  - Digits at or below DP_POS are never blanked. Codes 10-15 on digits_in are not treated as zero.
  - decimal = (idx == DP_POS) && (DP_POS < NUM_DIGITS-1).
- Reset (rst_n=0 sampled at a clk edge):
  - cnt=0, idx=0, a_digits=0, a_neg=0, a_lz=0, p_valid=0, frame_done=0.
  - Outputs during and after reset: digit_sel=...0001, num=0, decimal=(DP_POS==0).
  - Reset mid-frame discards any pending data.
- load during reset is ignored.
- Width rules: idx is $clog2(NUM_DIGITS) bits and cnt is $clog2(SCAN_DIV) bits, each a minimum of 1 bit.

Decomposition:
- Package display_pkg:
  - typedef digit_t (logic [3:0]).
  - Constants DIGIT_MINUS=4'd10 and DIGIT_BLANK=4'd11, shared with the 7-segment decoder.
- Sub-module display_scan_timer(SCAN_DIV, NUM_DIGITS):
  - Contains the prescaler and idx counter.
  - Outputs idx, tick and wrap.
- Buffers, blanking and output muxing stay in display_scan_mux.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, DP_POS=1.
1. Hold rst_n=0 for 2 cycles, then release -> digit_sel=0001, num=0, decimal=0, frame_done=0. digit_sel steps 0010, 0100, 1000 every 4 cycles. frame_done pulses in the 17th cycle after release and every 16 cycles thereafter.
2. load with digits_in={2,5,7}, neg=1, blank_lz=0 -> from the frame after the next wrap, num sequence per idx 0..3 is 7, 5 (decimal=1), 2, 10.
3. Frame holds {2,5,7}; load {9,9,9} while idx=2 -> idx2 and idx3 still show 2 and 10 (old frame); idx0 of the next frame shows 9.
4. load {0,0,3}, neg=0, blank_lz=1 -> num 3, 0 (decimal=1), 11, 11. The same value with blank_lz=0 -> 3, 0, 0, 11.
5. load {1,2,3} asserted in the exact wrap cycle -> idx0 of the immediately following frame shows 3. Two loads in one frame, {4,4,4} then {6,6,6} -> the next frame shows 6, 6, 6.
6. rst_n=0 for 1 cycle while idx=2 with a pending load -> idx=0, num=0 on every magnitude digit, sign digit shows 11, and the pending value never appears.
